key_search_ctrl: RTL and testbench

Brute-force key-sweep controller for the RC4 decryption datapath. Steps a candidate key through a parameterised range and launches one decrypt attempt per key. It waits for each attempt's verdict and, on the first valid plaintext, emits a one-cycle load pulse with the winning key. Sits upstream of the key-capture register: `key_out` drives its data bus and `key_load` drives its enable.

---
 rtl/rc4_pkg.sv | 14 +
 rtl/key_counter.sv | 45 ++++
 rtl/key_search_ctrl.sv | 124 ++++++++++++
 tb/tb_key_search_ctrl.sv | 270 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/rc4_pkg.sv
// Shared types and defaults for the RC4 key-search datapath.
package rc4_pkg;

    localparam int unsigned KEY_WIDTH_DEFAULT = 24;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        LAUNCH    = 3'd1,
        WAIT      = 3'd2,
        FOUND     = 3'd3,
        EXHAUSTED = 3'd4
    } key_search_state_t;

endpackage

// File: rtl/key_counter.sv
// Candidate-key up-counter with synchronous load of KEY_START and a registered at-end flag.
module key_counter
    import rc4_pkg::*;
#(
    parameter int unsigned          KEY_WIDTH = KEY_WIDTH_DEFAULT,
    parameter logic [KEY_WIDTH-1:0] KEY_START = '0,
    parameter logic [KEY_WIDTH-1:0] KEY_END   = '1
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 load_i,
    input  logic                 inc_i,
    output logic [KEY_WIDTH-1:0] count_o,
    output logic                 at_end_o
);

    logic [KEY_WIDTH-1:0] count_q;
    logic [KEY_WIDTH-1:0] count_d;
    logic                 at_end_q;

    // Next count: load has priority over increment; the FSM never increments at KEY_END.
    always_comb begin
        count_d = count_q;
        if (load_i) begin
            count_d = KEY_START;
        end else if (inc_i) begin
            count_d = count_q + KEY_WIDTH'(1);
        end
    end

    // Count register; at_end is precomputed from the next count so it is glitch-free.
    always_ff @(posedge clk) begin
        if (reset) begin
            count_q  <= KEY_START;
            at_end_q <= (KEY_START == KEY_END);
        end else begin
            count_q  <= count_d;
            at_end_q <= (count_d == KEY_END);
        end
    end

    assign count_o  = count_q;
    assign at_end_o = at_end_q;

endmodule

// File: rtl/key_search_ctrl.sv
// Brute-force key-sweep controller: launches one decrypt attempt per key and reports the first hit.
module key_search_ctrl
    import rc4_pkg::*;
#(
    parameter int unsigned          KEY_WIDTH = KEY_WIDTH_DEFAULT,
    parameter logic [KEY_WIDTH-1:0] KEY_START = '0,
    parameter logic [KEY_WIDTH-1:0] KEY_END   = '1
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 start,
    input  logic                 stop,
    input  logic                 core_done,
    input  logic                 core_valid,
    output logic                 core_start,
    output logic [KEY_WIDTH-1:0] key_out,
    output logic                 key_load,
    output logic                 busy,
    output logic                 found,
    output logic                 exhausted
);

    // An empty sweep range is a configuration error.
    if (KEY_START > KEY_END) begin : g_range_check
        $error("key_search_ctrl: KEY_START must not exceed KEY_END");
    end

    key_search_state_t state_q;
    logic              core_start_q;
    logic              key_load_q;
    logic              busy_q;
    logic              found_q;
    logic              exhausted_q;

    logic              load_c;
    logic              inc_c;
    logic              at_end;

    key_counter #(
        .KEY_WIDTH (KEY_WIDTH),
        .KEY_START (KEY_START),
        .KEY_END   (KEY_END)
    ) u_key_counter (
        .clk      (clk),
        .reset    (reset),
        .load_i   (load_c),
        .inc_i    (inc_c),
        .count_o  (key_out),
        .at_end_o (at_end)
    );

    // Counter controls: load on an accepted start, step on a failing verdict short of KEY_END.
    always_comb begin
        load_c = 1'b0;
        inc_c  = 1'b0;
        case (state_q)
            IDLE, FOUND, EXHAUSTED: load_c = start;
            WAIT:                   inc_c  = core_done && !core_valid && !stop && !at_end;
            default:                ;
        endcase
    end

    // Sweep FSM with every status output held in its own flop.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= IDLE;
            core_start_q <= 1'b0;
            key_load_q   <= 1'b0;
            busy_q       <= 1'b0;
            found_q      <= 1'b0;
            exhausted_q  <= 1'b0;
        end else begin
            core_start_q <= 1'b0;
            key_load_q   <= 1'b0;
            case (state_q)
                IDLE, FOUND, EXHAUSTED: begin
                    if (start) begin
                        state_q      <= LAUNCH;
                        core_start_q <= 1'b1;
                        busy_q       <= 1'b1;
                        found_q      <= 1'b0;
                        exhausted_q  <= 1'b0;
                    end
                end
                LAUNCH: begin
                    state_q <= WAIT;
                end
                WAIT: begin
                    if (core_done && core_valid) begin
                        state_q    <= FOUND;
                        key_load_q <= 1'b1;
                        found_q    <= 1'b1;
                        busy_q     <= 1'b0;
                    end else if (stop) begin
                        state_q <= IDLE;
                        busy_q  <= 1'b0;
                    end else if (core_done) begin
                        if (at_end) begin
                            state_q     <= EXHAUSTED;
                            exhausted_q <= 1'b1;
                            busy_q      <= 1'b0;
                        end else begin
                            state_q      <= LAUNCH;
                            core_start_q <= 1'b1;
                        end
                    end
                end
                default: begin
                    state_q     <= IDLE;
                    busy_q      <= 1'b0;
                    found_q     <= 1'b0;
                    exhausted_q <= 1'b0;
                end
            endcase
        end
    end

    assign core_start = core_start_q;
    assign key_load   = key_load_q;
    assign busy       = busy_q;
    assign found      = found_q;
    assign exhausted  = exhausted_q;

endmodule

// File: tb/tb_key_search_ctrl.sv
// Scoreboard bench for key_search_ctrl: three instances with different sweep ranges.
module tb_key_search_ctrl;

    logic       clk;
    logic       reset;
    logic [2:0] start_v, stop_v, done_v, valid_v;
    logic [2:0] cs_v, kl_v, busy_v, found_v, exh_v;
    logic [7:0] ko0, ko1;
    logic [3:0] ko2;

    int total = 0;
    int bad   = 0;

    typedef struct packed {
        logic [1:0] dut;
        logic       load;
        logic [7:0] key;
    } ev_t;

    ev_t exp_q[$];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    key_search_ctrl #(.KEY_WIDTH(8), .KEY_START(8'd0), .KEY_END(8'd7)) dut0 (
        .clk(clk), .reset(reset), .start(start_v[0]), .stop(stop_v[0]),
        .core_done(done_v[0]), .core_valid(valid_v[0]), .core_start(cs_v[0]),
        .key_out(ko0), .key_load(kl_v[0]), .busy(busy_v[0]), .found(found_v[0]),
        .exhausted(exh_v[0]));

    key_search_ctrl #(.KEY_WIDTH(8), .KEY_START(8'd0), .KEY_END(8'd3)) dut1 (
        .clk(clk), .reset(reset), .start(start_v[1]), .stop(stop_v[1]),
        .core_done(done_v[1]), .core_valid(valid_v[1]), .core_start(cs_v[1]),
        .key_out(ko1), .key_load(kl_v[1]), .busy(busy_v[1]), .found(found_v[1]),
        .exhausted(exh_v[1]));

    key_search_ctrl #(.KEY_WIDTH(4), .KEY_START(4'd14), .KEY_END(4'd15)) dut2 (
        .clk(clk), .reset(reset), .start(start_v[2]), .stop(stop_v[2]),
        .core_done(done_v[2]), .core_valid(valid_v[2]), .core_start(cs_v[2]),
        .key_out(ko2), .key_load(kl_v[2]), .busy(busy_v[2]), .found(found_v[2]),
        .exhausted(exh_v[2]));

    function automatic logic [7:0] ko_of(int i);
        case (i)
            0:       return ko0;
            1:       return ko1;
            default: return {4'd0, ko2};
        endcase
    endfunction

    task automatic chk(string nm, logic [7:0] act, logic [7:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d want %0d", nm, act, exp);
        end
    endtask

    task automatic exp_push(int i, bit ld, int k);
        ev_t e;
        e.dut  = 2'(i);
        e.load = ld;
        e.key  = 8'(k);
        exp_q.push_back(e);
    endtask

    // Monitor: every launch or load pulse must match the oldest expected event.
    task automatic check_ev(int i, bit ld);
        ev_t e;
        total++;
        if (exp_q.size() == 0) begin
            bad++;
            $display("FAIL unexpected_%s dut%0d: key %0d, none expected",
                     ld ? "load" : "launch", i, ko_of(i));
        end else begin
            e = exp_q.pop_front();
            if (e.dut != 2'(i) || e.load != ld || e.key != ko_of(i)) begin
                bad++;
                $display("FAIL event dut%0d: got %s key %0d, want dut%0d %s key %0d",
                         i, ld ? "load" : "launch", ko_of(i),
                         e.dut, e.load ? "load" : "launch", e.key);
            end
        end
    endtask

    initial begin
        forever begin
            @(negedge clk);
            for (int i = 0; i < 3; i++) begin
                if (cs_v[i] === 1'b1) check_ev(i, 1'b0);
                if (kl_v[i] === 1'b1) check_ev(i, 1'b1);
            end
        end
    end

    // Wait (bounded) for a launch pulse; returns at the negedge of the LAUNCH cycle.
    task automatic wait_launch(int i);
        bit seen = 1'b0;
        for (int n = 0; n < 20; n++) begin
            @(negedge clk);
            if (cs_v[i] === 1'b1) begin
                seen = 1'b1;
                break;
            end
        end
        if (!seen) begin
            total++;
            bad++;
            $display("FAIL launch_timeout dut%0d: got no core_start, want one", i);
        end
    endtask

    // Core response: verdict in the WAIT cycle right after LAUNCH; optional start while busy.
    task automatic verdict(int i, bit v, bit stp, bit st);
        start_v[i] = st;
        @(posedge clk); #1;
        start_v[i] = st;
        done_v[i]  = 1'b1;
        valid_v[i] = v;
        stop_v[i]  = stp;
        @(posedge clk); #1;
        start_v[i] = 1'b0;
        done_v[i]  = 1'b0;
        valid_v[i] = 1'b0;
        stop_v[i]  = 1'b0;
    endtask

    task automatic pulse_start(int i);
        @(posedge clk); #1;
        start_v[i] = 1'b1;
        @(posedge clk); #1;
        start_v[i] = 1'b0;
    endtask

    initial begin
        reset   = 1'b1;
        start_v = '0;
        stop_v  = '0;
        done_v  = '0;
        valid_v = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_flags", 8'({cs_v, kl_v}), 8'd0);
        chk("rst_status", 8'({busy_v, found_v}), 8'd0);
        chk("rst_exh", 8'(exh_v), 8'd0);
        chk("rst_key0", ko0, 8'd0);
        chk("rst_key2", {4'd0, ko2}, 8'd14);
        @(posedge clk); #1;
        reset = 1'b0;

        // Sweep 0..7, hit on key 3, with start pulsed while busy.
        exp_push(0, 1'b0, 0);
        pulse_start(0);
        for (int k = 0; k < 4; k++) begin
            wait_launch(0);
            if (k == 1) chk("busy_in_launch", 8'(busy_v[0]), 8'd1);
            if (k < 3) begin
                exp_push(0, 1'b0, k + 1);
                verdict(0, 1'b0, 1'b0, k == 1 || k == 2);
            end else begin
                exp_push(0, 1'b1, 3);
                verdict(0, 1'b1, 1'b0, 1'b0);
            end
        end
        @(negedge clk);
        chk("t1_found", 8'(found_v[0]), 8'd1);
        chk("t1_busy", 8'(busy_v[0]), 8'd0);
        chk("t1_key", ko0, 8'd3);
        @(negedge clk);
        chk("t1_load_drop", 8'(kl_v[0]), 8'd0);
        chk("t1_found_hold", 8'(found_v[0]), 8'd1);

        // Restart from FOUND, then valid verdict together with stop: found wins.
        exp_push(0, 1'b0, 0);
        pulse_start(0);
        wait_launch(0);
        chk("restart_load_low", 8'(kl_v[0]), 8'd0);
        chk("restart_found_low", 8'(found_v[0]), 8'd0);
        exp_push(0, 1'b0, 1);
        verdict(0, 1'b0, 1'b0, 1'b0);
        wait_launch(0);
        exp_push(0, 1'b1, 1);
        verdict(0, 1'b1, 1'b1, 1'b0);
        @(negedge clk);
        chk("stopvalid_found", 8'(found_v[0]), 8'd1);
        chk("stopvalid_key", ko0, 8'd1);

        // Invalid verdict together with stop: back to IDLE, no increment.
        exp_push(0, 1'b0, 0);
        pulse_start(0);
        wait_launch(0);
        exp_push(0, 1'b0, 1);
        verdict(0, 1'b0, 1'b0, 1'b0);
        wait_launch(0);
        verdict(0, 1'b0, 1'b1, 1'b0);
        @(negedge clk);
        chk("stopinv_status", 8'({busy_v[0], found_v[0], exh_v[0]}), 8'd0);
        chk("stopinv_key", ko0, 8'd1);
        @(negedge clk);
        chk("stopinv_idle", 8'(cs_v[0]), 8'd0);

        // Sweep 0..3, all invalid: exhaust at 3 without wrapping.
        exp_push(1, 1'b0, 0);
        pulse_start(1);
        for (int k = 0; k < 4; k++) begin
            wait_launch(1);
            if (k < 3) exp_push(1, 1'b0, k + 1);
            verdict(1, 1'b0, 1'b0, 1'b0);
        end
        @(negedge clk);
        chk("t2_exh", 8'(exh_v[1]), 8'd1);
        chk("t2_busy", 8'(busy_v[1]), 8'd0);
        chk("t2_found", 8'(found_v[1]), 8'd0);
        chk("t2_key", ko1, 8'd3);
        repeat (3) @(negedge clk);
        chk("t2_key_hold", ko1, 8'd3);

        // 4-bit sweep 14..15 ending on all-ones: no wrap.
        exp_push(2, 1'b0, 14);
        pulse_start(2);
        for (int k = 14; k < 16; k++) begin
            wait_launch(2);
            if (k < 15) exp_push(2, 1'b0, k + 1);
            verdict(2, 1'b0, 1'b0, 1'b0);
        end
        @(negedge clk);
        chk("t3_exh", 8'(exh_v[2]), 8'd1);
        chk("t3_key", {4'd0, ko2}, 8'd15);
        repeat (2) @(negedge clk);
        chk("t3_key_hold", {4'd0, ko2}, 8'd15);

        // Reset while waiting on key 5, then a stale verdict after release.
        exp_push(0, 1'b0, 0);
        pulse_start(0);
        for (int k = 0; k < 5; k++) begin
            wait_launch(0);
            exp_push(0, 1'b0, k + 1);
            verdict(0, 1'b0, 1'b0, 1'b0);
        end
        wait_launch(0);
        @(posedge clk); #1;
        reset = 1'b1;
        @(negedge clk);
        chk("midrst_key", ko0, 8'd5);
        @(negedge clk);
        chk("midrst_key_start", ko0, 8'd0);
        chk("midrst_busy", 8'(busy_v[0]), 8'd0);
        @(posedge clk); #1;
        reset      = 1'b0;
        done_v[0]  = 1'b1;
        valid_v[0] = 1'b1;
        @(posedge clk); #1;
        done_v[0]  = 1'b0;
        valid_v[0] = 1'b0;
        @(negedge clk);
        chk("late_status", 8'({busy_v[0], found_v[0], exh_v[0]}), 8'd0);
        chk("late_key", ko0, 8'd0);
        repeat (3) @(negedge clk);

        total++;
        if (exp_q.size() != 0) begin
            bad++;
            $display("FAIL pending_events: got %0d left, want 0", exp_q.size());
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
